// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction-fetch PC controller for a 5-stage MIPS pipeline.
// Owns the PC register and selects between PC+4, jump, jr and branch targets.
// Handles hazard stalls, queues redirects that arrive during a stall, and
// issues flush pulses to IF/ID and ID/EX.
// Optional build macro DELAY_SLOT_EN: when defined, the branch delay slot is
// honoured (jump/jr do not flush IF/ID; branch flushes ID/EX only).
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_W     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inStall,
  input  logic            inBranchTaken,
  input  logic [PC_W-1:0] inBranchTarget,
  input  logic            inJump,
  input  logic [PC_W-1:0] inJumpTarget,
  input  logic            inJr,
  input  logic [PC_W-1:0] inJrTarget,
  output logic [PC_W-1:0] outPc,
  output logic [PC_W-1:0] outPostPc,
  output logic            outFetchValid,
  output logic            outFlushIF,
  output logic            outFlushID,
  output logic            outMisalign
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD, PEND} state_t;
  // Encoded so that a numerically larger source has higher priority.
  typedef enum logic [1:0] {SRC_NONE, SRC_JUMP, SRC_JR, SRC_BR} src_t;

  state_t          state, state_next;
  logic [PC_W-1:0] pc, pc_next;
  logic [PC_W-1:0] pend_pc, pend_pc_next;
  src_t            pend_src, pend_src_next;
  logic            misalign;

  src_t            win_src;
  logic [PC_W-1:0] win_raw;
  logic [PC_W-1:0] win_pc;
  logic            accept;

  // Pick the highest-priority redirect currently requested.
  always_comb begin
    win_src = SRC_NONE;
    win_raw = '0;
    if (inBranchTaken) begin
      win_src = SRC_BR;
      win_raw = inBranchTarget;
    end else if (inJr) begin
      win_src = SRC_JR;
      win_raw = inJrTarget;
    end else if (inJump) begin
      win_src = SRC_JUMP;
      win_raw = inJumpTarget;
    end
    win_pc = {win_raw[PC_W-1:2], 2'b00};
  end

  // State, PC, pending target and sticky misalign registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_PC[PC_W-1:0];
      pend_pc  <= '0;
      pend_src <= SRC_NONE;
      misalign <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      pend_pc  <= pend_pc_next;
      pend_src <= pend_src_next;
      if (accept && (win_raw[1:0] != 2'b00)) misalign <= 1'b1;
    end
  end

  // Next-state, next-PC and pending-register selection.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    pend_pc_next  = pend_pc;
    pend_src_next = pend_src;
    accept        = 1'b0;
    case (state)
      BOOT: state_next = RUN;
      // HOLD with the stall released behaves exactly like RUN.
      RUN, HOLD: begin
        if (inStall) begin
          if (win_src != SRC_NONE) begin
            accept        = 1'b1;
            pend_pc_next  = win_pc;
            pend_src_next = win_src;
            state_next    = PEND;
          end else begin
            state_next = HOLD;
          end
        end else begin
          state_next = RUN;
          if (win_src != SRC_NONE) begin
            accept  = 1'b1;
            pc_next = win_pc;
          end else begin
            pc_next = pc + 32'd4;
          end
        end
      end
      // An equal-or-higher priority redirect supersedes the queued one; if the
      // stall drops in the same cycle it loads directly instead of being queued.
      PEND: begin
        if ((win_src != SRC_NONE) && (win_src >= pend_src)) begin
          accept = 1'b1;
          if (inStall) begin
            pend_pc_next  = win_pc;
            pend_src_next = win_src;
          end else begin
            pc_next       = win_pc;
            pend_pc_next  = '0;
            pend_src_next = SRC_NONE;
            state_next    = RUN;
          end
        end else if (!inStall) begin
          pc_next       = pend_pc;
          pend_pc_next  = '0;
          pend_src_next = SRC_NONE;
          state_next    = RUN;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  // Fetch-valid and flush pulses for the accepted redirect.
  always_comb begin
    outFetchValid = (state != BOOT);
    outFlushIF    = 1'b0;
    outFlushID    = 1'b0;
    if (accept) begin
`ifdef DELAY_SLOT_EN
      outFlushID = (win_src == SRC_BR);
`else
      outFlushIF = 1'b1;
      outFlushID = (win_src == SRC_BR);
`endif
    end
  end

  assign outPc       = pc;
  assign outPostPc   = pc + 32'd4;
  assign outMisalign = misalign;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inStall;
  logic        inBranchTaken;
  logic [31:0] inBranchTarget;
  logic        inJump;
  logic [31:0] inJumpTarget;
  logic        inJr;
  logic [31:0] inJrTarget;
  logic [31:0] outPc;
  logic [31:0] outPostPc;
  logic        outFetchValid;
  logic        outFlushIF;
  logic        outFlushID;
  logic        outMisalign;

  int checks   = 0;
  int failures = 0;

`ifdef DELAY_SLOT_EN
  localparam logic DS = 1'b1;
`else
  localparam logic DS = 1'b0;
`endif
  // Expected IF/ID flush for any accepted redirect.
  localparam logic EXP_FIF = !DS;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .inStall(inStall),
    .inBranchTaken(inBranchTaken), .inBranchTarget(inBranchTarget),
    .inJump(inJump), .inJumpTarget(inJumpTarget),
    .inJr(inJr), .inJrTarget(inJrTarget),
    .outPc(outPc), .outPostPc(outPostPc), .outFetchValid(outFetchValid),
    .outFlushIF(outFlushIF), .outFlushID(outFlushID), .outMisalign(outMisalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_fl(input string tag, input logic fif, input logic fid);
    chk({tag, "_flushIF"}, {31'd0, outFlushIF}, {31'd0, fif});
    chk({tag, "_flushID"}, {31'd0, outFlushID}, {31'd0, fid});
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    inStall = 0; inBranchTaken = 0; inJump = 0; inJr = 0;
    inBranchTarget = '0; inJumpTarget = '0; inJrTarget = '0;
  endtask

  initial begin
    rst_n = 0;
    clr();
    #2;
    chk("rst_pc", outPc, 32'h0);
    chk("rst_postpc", outPostPc, 32'h4);
    chk("rst_fv", {31'd0, outFetchValid}, 32'd0);
    chk_fl("rst", 1'b0, 1'b0);
    chk("rst_mis", {31'd0, outMisalign}, 32'd0);
    step(); step();
    rst_n = 1;
    #1;
    chk("boot_fv", {31'd0, outFetchValid}, 32'd0);
    chk_fl("boot", 1'b0, 1'b0);
    step();
    chk("run_fv", {31'd0, outFetchValid}, 32'd1);
    chk("seq0", outPc, 32'h0);
    step(); chk("seq4", outPc, 32'h4);
    step(); chk("seq8", outPc, 32'h8);
    step(); chk("seqC", outPc, 32'hC);
    chk_fl("seq", 1'b0, 1'b0);

    // Reach 0x0040_0010, then the planned jump.
    inJump = 1; inJumpTarget = 32'h0040_0010; #1;
    step(); clr(); chk("pc_400010", outPc, 32'h0040_0010);
    inJump = 1; inJumpTarget = 32'h0040_0100; #1;
    chk_fl("jump", EXP_FIF, 1'b0);
    step(); clr(); #1;
    chk("jump_pc", outPc, 32'h0040_0100);
    chk_fl("after_jump", 1'b0, 1'b0);

    // Branch beats a simultaneous jump.
    inBranchTaken = 1; inBranchTarget = 32'h200; inJump = 1; inJumpTarget = 32'h300; #1;
    chk_fl("prio", EXP_FIF, 1'b1);
    step(); clr();
    chk("prio_pc", outPc, 32'h200);

    // Stall with jr captured, stall held 3 cycles.
    inStall = 1; inJr = 1; inJrTarget = 32'h1000; #1;
    chk_fl("cap", EXP_FIF, 1'b0);
    chk("cap_fv", {31'd0, outFetchValid}, 32'd1);
    step(); inJr = 0; #1;
    chk("stall1_pc", outPc, 32'h200);
    chk_fl("stall1", 1'b0, 1'b0);
    step(); chk("stall2_pc", outPc, 32'h200);
    step(); chk("stall3_pc", outPc, 32'h200);
    inStall = 0; #1;
    chk_fl("release", 1'b0, 1'b0);
    step();
    chk("pend_load", outPc, 32'h1000);
    chk_fl("post_load", 1'b0, 1'b0);

    // Plain stall to HOLD, then a jump when the stall drops.
    inStall = 1; #1;
    chk_fl("hold_enter", 1'b0, 1'b0);
    step(); chk("hold_pc", outPc, 32'h1000);
    inStall = 0; inJump = 1; inJumpTarget = 32'h2000; #1;
    chk_fl("hold_jump", EXP_FIF, 1'b0);
    step(); clr();
    chk("hold_jump_pc", outPc, 32'h2000);

    // PEND: jr queued, lower-priority jump ignored, branch at release wins.
    inStall = 1; inJr = 1; inJrTarget = 32'h4000; #1;
    step(); clr(); inStall = 1; inJump = 1; inJumpTarget = 32'h5000; #1;
    chk_fl("pend_low", 1'b0, 1'b0);
    step(); clr(); chk("pend_hold_pc", outPc, 32'h2000);
    inBranchTaken = 1; inBranchTarget = 32'h6000; #1;
    chk_fl("pend_br", EXP_FIF, 1'b1);
    step(); clr();
    chk("pend_br_pc", outPc, 32'h6000);
    step(); chk("pend_br_seq", outPc, 32'h6004);

    // Equal-priority replacement in PEND.
    inStall = 1; inJump = 1; inJumpTarget = 32'h3000; #1;
    step(); inJumpTarget = 32'h3100; #1;
    chk_fl("pend_eq", EXP_FIF, 1'b0);
    step(); clr(); #1;
    step(); chk("pend_eq_pc", outPc, 32'h3100);

    // Misaligned jump target.
    chk("mis_before", {31'd0, outMisalign}, 32'd0);
    inJump = 1; inJumpTarget = 32'h0000_0102; #1;
    step(); clr();
    chk("mis_pc", outPc, 32'h100);
    chk("mis_set", {31'd0, outMisalign}, 32'd1);
    step(); step();
    chk("mis_sticky", {31'd0, outMisalign}, 32'd1);

    // Wrap-around.
    inJump = 1; inJumpTarget = 32'hFFFF_FFFC; #1;
    step(); clr();
    chk("wrap_pc", outPc, 32'hFFFF_FFFC);
    chk("wrap_post", outPostPc, 32'h0);
    step();
    chk("wrap_next", outPc, 32'h0);
    chk("wrap_mis", {31'd0, outMisalign}, 32'd1);

    // Asynchronous reset while in PEND.
    inStall = 1; inBranchTaken = 1; inBranchTarget = 32'h8000; #1;
    step(); clr(); inStall = 1;
    #2;
    rst_n = 0;
    #1;
    chk("arst_pc", outPc, 32'h0);
    chk("arst_fv", {31'd0, outFetchValid}, 32'd0);
    chk("arst_mis", {31'd0, outMisalign}, 32'd0);
    chk_fl("arst", 1'b0, 1'b0);
    step();
    clr(); rst_n = 1; #1;
    chk("arst_boot_fv", {31'd0, outFetchValid}, 32'd0);
    step(); chk("arst_run0", outPc, 32'h0);
    step(); chk("arst_run4", outPc, 32'h4);
    step(); chk("arst_run8", outPc, 32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Instruction-fetch PC controller for the 5-stage MIPS pipeline.
- Owns the PC register and selects the next PC from four sources: sequential PC+4, pseudo-direct jump target (PC[31:28] concatenated with instr[25:0] shifted left 2, computed in ID), jump-register target, and branch target (resolved in EX).
- Applies stalls from hazard detection, queues redirects that arrive during a stall, and issues flush pulses to the IF/ID and ID/EX latches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_W, 32, PC width. Fixed at 32; the jump-target format depends on it.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- inStall  in  1  hold PC; IF/ID keeps its contents.
- inBranchTaken  in  1  EX-stage branch resolved as taken.
- inBranchTarget  in  32  branch target from EX.
- inJump  in  1  ID decodes j/jal.
- inJumpTarget  in  32  pseudo-direct jump target from ID.
- inJr  in  1  ID decodes jr/jalr.
- inJrTarget  in  32  register value for jr.
- outPc  out  32  current fetch address to instruction memory.
- outPostPc  out  32  outPc+4; bits [31:28] feed jump-target formation.
- outFetchValid  out  1  outPc is a valid fetch this cycle.
- outFlushIF  out  1  clear IF/ID this cycle.
- outFlushID  out  1  clear ID/EX this cycle.
- outMisalign  out  1  sticky: a redirect target had bits[1:0] != 0.

Behaviour:
- Reset (rst_n=0, asynchronous): outPc=RESET_PC, outPostPc=RESET_PC+4, outFetchValid=0, outFlushIF=0, outFlushID=0, outMisalign=0, pending register cleared, state=BOOT.
- States: BOOT, RUN, HOLD, PEND.
- BOOT: one cycle with outFetchValid=0 and PC unchanged, then RUN. All inputs are ignored in BOOT.
- RUN:
  - outFetchValid=1.
  - Next PC priority: inBranchTaken > inJr > inJump > PC+4.
  - Rationale: an EX branch is older than the instruction in ID, so it wins.
- Redirect without inStall:
  - PC loads the target on the next edge (1-cycle latency).
  - Combinational outputs in the same cycle:
    - Branch: outFlushIF=1 and outFlushID=1.
    - Jump or jr: outFlushIF=1 only.
- Redirect targets: bits[1:0] are forced to 00 when loaded. If the raw target had bits[1:0] != 0, outMisalign sets and stays set until reset.
- inStall=1 in RUN:
  - PC holds. outFetchValid stays 1 (refetch of the same address).
  - No redirect present: go to HOLD.
  - Redirect present: latch the winning target into the pending register, assert its flushes this cycle, go to PEND.
- HOLD:
  - PC holds while inStall=1.
  - Redirect arriving while still stalled: latch it, assert its flushes, go to PEND.
  - inStall=0: behave exactly as RUN this cycle, including any redirect now present.
- PEND:
  - PC holds.
  - A newer redirect of higher or equal priority replaces the pending target and asserts its flushes. A lower-priority one is ignored.
  - A branch always replaces a pending jump/jr.
  - inStall=0: PC loads the pending target on that edge, pending is cleared, state goes to RUN. No additional flush is issued, since it was issued at capture.
- Simultaneous inStall=0 and a new branch in PEND: the branch wins and loads directly.
- Wrap-around: PC+4 wraps modulo 2^32 (32'hFFFF_FFFC goes to 0). No flag is raised.
- Flush outputs are combinational single-cycle pulses and are never asserted in BOOT or during reset.

Optional Feature:
- Macro: DELAY_SLOT_EN.
- Defined: MIPS branch delay slot honoured.
  - Jump and jr do not assert outFlushIF.
  - Branch asserts outFlushID only; the IF/ID delay-slot instruction survives.
  - Redirect timing is unchanged.
- Undefined: flush behaviour exactly as in Behaviour above.

Test Plan:
- Reset and boot:
  - Release rst_n with RESET_PC=0.
  - Expect outFetchValid=0 for one cycle.
  - Then outPc sequence 0,4,8,C with no flushes.
- Jump:
  - At outPc=0x0040_0010, pulse inJump with inJumpTarget=0x0040_0100.
  - Expect outFlushIF=1 that cycle, outPc=0x0040_0100 on the next edge, outFlushID=0.
- Priority:
  - Assert inBranchTaken (target 0x200) together with inJump (target 0x300).
  - Expect next outPc=0x200 and outFlushIF=outFlushID=1.
- Stall with redirect:
  - Raise inStall, pulse inJr with target 0x1000, hold inStall for 3 cycles.
  - Expect PC frozen and flushes only in the capture cycle.
  - Expect outPc=0x1000 on the edge after inStall falls.
- Misalign and wrap:
  - Jump to 0x0000_0102: expect outPc=0x100 and outMisalign=1, held until reset.
  - From outPc=0xFFFF_FFFC: expect next outPc=0.
- Asynchronous reset mid-operation:
  - Assert rst_n=0 while in PEND.
  - Expect immediate outPc=RESET_PC and pending discarded; after release, BOOT then sequential fetch.
